// File: rtl/dff_share_arbiter_if.sv
// Requester-side bundle for the shared-register arbiter: request/lock/data in,
// registered grant and shared register contents out.
interface dff_share_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 8
);
   localparam int unsigned OWN_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        lock;
   logic [NUM_REQ*DATA_W-1:0] d_in;
   logic [NUM_REQ-1:0]        gnt;
   logic [DATA_W-1:0]         q;
   logic [OWN_W-1:0]          q_owner;
   logic                      q_valid;
   logic                      locked;

   modport master (
      output req, lock, d_in,
      input  gnt, q, q_owner, q_valid, locked
   );

   modport slave (
      input  req, lock, d_in,
      output gnt, q, q_owner, q_valid, locked
   );
endinterface

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one DATA_W-bit register among NUM_REQ requesters,
// with capped back-to-back ownership for requesters holding lock.
module dff_share_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned HOLD_MAX = 4
) (
   input logic                clk,
   input logic                rst,
   dff_share_arbiter_if.slave bus
);
   localparam int unsigned OWN_W  = $clog2(NUM_REQ);
   localparam int unsigned HCNT_W = $clog2(HOLD_MAX + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      LOCKED = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [HCNT_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic [OWN_W-1:0]     last_q, last_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [DATA_W-1:0]    q_q, q_d;
   logic [OWN_W-1:0]     q_owner_q, q_owner_d;
   logic                 q_valid_q, q_valid_d;
   logic                 locked_q, locked_d;

   logic [NUM_REQ-1:0]   elig_c;
   logic [NUM_REQ-1:0]   owner_oh_c;
   logic [OWN_W:0]       pick_all_c;
   logic [OWN_W:0]       pick_oth_c;
   logic                 own_hold_c;
   logic                 grant_c;
   logic                 cont_c;
   logic [OWN_W-1:0]     win_c;

   // First set bit of mask searching upward from last+1 with wrap; MSB flags a hit.
   function automatic logic [OWN_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                              input logic [OWN_W-1:0]   last);
      logic [OWN_W:0] res;
      int unsigned    base;
      int unsigned    idx;
      res  = '0;
      base = 32'(last);
      for (int unsigned k = NUM_REQ; k >= 1; k--) begin
         idx = (base + k) % NUM_REQ;
         if (mask[idx]) res = {1'b1, OWN_W'(idx)};
      end
      return res;
   endfunction

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      last_d     = last_q;
      gnt_d      = '0;
      q_d        = q_q;
      q_owner_d  = q_owner_q;
      q_valid_d  = 1'b0;
      grant_c    = 1'b0;
      cont_c     = 1'b0;
      win_c      = '0;

      // A requester granted last edge sits out one edge unless it keeps lock.
      elig_c     = bus.req & ~(gnt_q & ~bus.lock);
      owner_oh_c = NUM_REQ'(1) << last_q;
      pick_all_c = rr_pick(elig_c, last_q);
      pick_oth_c = rr_pick(elig_c & ~owner_oh_c, last_q);
      own_hold_c = (state_q == LOCKED) && bus.req[last_q] && bus.lock[last_q];

      if (own_hold_c) begin
         if (hold_cnt_q < HCNT_W'(HOLD_MAX)) begin
            grant_c = 1'b1;
            cont_c  = 1'b1;
            win_c   = last_q;
         end else if (pick_oth_c[OWN_W]) begin
            grant_c = 1'b1;
            win_c   = pick_oth_c[OWN_W-1:0];
         end else begin
            grant_c = 1'b1;
            cont_c  = 1'b1;
            win_c   = last_q;
         end
      end else if (pick_all_c[OWN_W]) begin
         grant_c = 1'b1;
         win_c   = pick_all_c[OWN_W-1:0];
      end

      if (grant_c) begin
         gnt_d     = NUM_REQ'(1) << win_c;
         q_d       = bus.d_in[32'(win_c)*DATA_W +: DATA_W];
         q_owner_d = win_c;
         q_valid_d = 1'b1;
         last_d    = win_c;
         if (cont_c) begin
            state_d    = LOCKED;
            hold_cnt_d = (hold_cnt_q >= HCNT_W'(HOLD_MAX)) ? HCNT_W'(1)
                                                           : hold_cnt_q + HCNT_W'(1);
         end else if (bus.lock[win_c]) begin
            state_d    = LOCKED;
            hold_cnt_d = HCNT_W'(1);
         end else begin
            state_d    = GRANT;
            hold_cnt_d = '0;
         end
      end else begin
         state_d    = IDLE;
         hold_cnt_d = '0;
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         last_q     <= OWN_W'(NUM_REQ - 1);
         gnt_q      <= '0;
         q_q        <= '0;
         q_owner_q  <= '0;
         q_valid_q  <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         last_q     <= last_d;
         gnt_q      <= gnt_d;
         q_q        <= q_d;
         q_owner_q  <= q_owner_d;
         q_valid_q  <= q_valid_d;
         locked_q   <= locked_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.q       = q_q;
   assign bus.q_owner = q_owner_q;
   assign bus.q_valid = q_valid_q;
   assign bus.locked  = locked_q;
endmodule
